// File: rtl/if_fetch_pkg.sv
// ---------------------------------------------------------------------------
// if_fetch_pkg
// Shared definitions for the instruction-fetch stage: fetch FSM state
// encodings, the default instruction-cache index width, and the width of the
// byte counter used while assembling a word over the 8-bit memory port.
// ---------------------------------------------------------------------------
package if_fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // look up the cache, present on hit
    ST_MISS = 2'd1,  // issue / capture the four bytes of the word
    ST_FILL = 2'd2   // word assembled, waiting for a free output slot
  } fetch_state_e;

  localparam int ICACHE_IDX_W_DEF = 7;

  // Counts issued bytes 0..4, so it needs one bit more than a byte lane.
  localparam int BYTE_CNT_W     = 3;
  localparam int BYTES_PER_INST = 4;

endpackage

// File: rtl/if_icache.sv
// ---------------------------------------------------------------------------
// if_icache
// Direct-mapped instruction cache with one 32-bit word per line.
//   clk        in   clock
//   rst_n      in   asynchronous active-low clear of all valid bits
//   i_rd_idx   in   read index
//   i_rd_tag   in   tag compared against the stored tag of the read line
//   o_hit      out  line valid and tag matches (combinational)
//   o_rd_data  out  stored word of the read line (combinational)
//   i_we       in   write enable (line becomes valid)
//   i_wr_idx   in   write index
//   i_wr_tag   in   write tag
//   i_wr_data  in   write data
// ---------------------------------------------------------------------------
module if_icache
  import if_fetch_pkg::*;
#(
  parameter int IDX_W = ICACHE_IDX_W_DEF,
  parameter int TAG_W = 32 - IDX_W - 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] i_rd_idx,
  input  logic [TAG_W-1:0] i_rd_tag,
  output logic             o_hit,
  output logic [31:0]      o_rd_data,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  logic [TAG_W-1:0] i_wr_tag,
  input  logic [31:0]      i_wr_data
);

  localparam int LINES = 2 ** IDX_W;

  logic [LINES-1:0] r_valid;
  logic [TAG_W-1:0] r_tag  [LINES];
  logic [31:0]      r_data [LINES];

  // NOTE: sequential state is always written with <= so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
    end else if (i_we) begin
      r_valid[i_wr_idx] <= 1'b1;
    end
  end

  // NOTE: tag/data storage is deliberately not reset; the valid bits alone
  // qualify a line, which lets these arrays map onto plain RAM.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_tag[i_wr_idx]  <= i_wr_tag;
      r_data[i_wr_idx] <= i_wr_data;
    end
  end

  assign o_hit     = r_valid[i_rd_idx] && (r_tag[i_rd_idx] == i_rd_tag);
  assign o_rd_data = r_data[i_rd_idx];

endmodule

// File: rtl/if_fetch.sv
// ---------------------------------------------------------------------------
// if_fetch
// Instruction-fetch stage. Holds the PC, looks it up in a direct-mapped
// cache and, on a miss, assembles the 32-bit word little-endian from four
// byte reads over the shared 8-bit memory port. Presents (pc, inst, valid)
// to the IF/ID register, honours stall and redirects on branch/jump.
//   clk                   in   clock
//   rst                   in   asynchronous active-low reset
//   stall_i               in   IF/ID cannot accept; hold presented instruction
//   branch_flag_i         in   redirect request from decode
//   branch_target_addr_i  in   redirect PC (bits [1:0] ignored)
//   mem_busy_i            in   memory port owned by the LSU this cycle
//   mem_din_i             in   read data, one cycle after the address
//   mem_a_o               out  byte address (holds when no request)
//   mem_req_o             out  fetch issues a read this cycle
//   pc_o                  out  PC of the presented instruction
//   inst_o                out  presented instruction
//   inst_valid_o          out  pc_o/inst_o valid
// ---------------------------------------------------------------------------
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter int          ICACHE_IDX_W = ICACHE_IDX_W_DEF,
  parameter logic [31:0] RESET_PC     = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_addr_i,
  input  logic        mem_busy_i,
  input  logic [7:0]  mem_din_i,
  output logic [31:0] mem_a_o,
  output logic        mem_req_o,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        inst_valid_o
);

  localparam int TAG_W = 32 - ICACHE_IDX_W - 2;

  fetch_state_e          r_state;
  logic [31:0]           r_pc;
  logic [BYTE_CNT_W-1:0] r_k;        // bytes issued so far for this miss
  logic                  r_pend;     // a byte was issued last cycle
  logic [1:0]            r_pend_j;   // lane of that byte
  logic [31:0]           r_buf;      // word under assembly
  logic [31:0]           r_last_a;
  logic [31:0]           r_pc_o;
  logic [31:0]           r_inst_o;
  logic                  r_valid;

  logic                    w_hit;
  logic [31:0]             w_line;
  logic [ICACHE_IDX_W-1:0] w_idx;
  logic [TAG_W-1:0]        w_tag;
  logic                    w_slot_free;
  logic                    w_issue;
  logic [31:0]             w_mem_a;
  logic                    w_last_byte;
  logic                    w_fill_we;
  logic [31:0]             w_fill_data;

  assign w_idx = r_pc[ICACHE_IDX_W+1:2];
  assign w_tag = r_pc[31:ICACHE_IDX_W+2];

  // The output slot can take a new instruction unless one is held by stall.
  assign w_slot_free = !r_valid || !stall_i;

  assign w_issue = (r_state == ST_MISS) && (r_k < BYTE_CNT_W'(BYTES_PER_INST))
                   && !mem_busy_i;
  assign w_mem_a = r_pc + 32'(r_k);

  // Byte 3 arrives this cycle: the word completes at this edge. The line is
  // written straight from the bus so an abort before this point (or a
  // redirect in this very cycle) leaves the cache untouched.
  assign w_last_byte = r_pend && (r_pend_j == 2'd3);
  assign w_fill_we   = (r_state == ST_MISS) && w_last_byte && !branch_flag_i;
  assign w_fill_data = {mem_din_i, r_buf[23:0]};

  if_icache #(
    .IDX_W (ICACHE_IDX_W),
    .TAG_W (TAG_W)
  ) u_icache (
    .clk       (clk),
    .rst_n     (rst),
    .i_rd_idx  (w_idx),
    .i_rd_tag  (w_tag),
    .o_hit     (w_hit),
    .o_rd_data (w_line),
    .i_we      (w_fill_we),
    .i_wr_idx  (w_idx),
    .i_wr_tag  (w_tag),
    .i_wr_data (w_fill_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_pc     <= RESET_PC;
      r_k      <= '0;
      r_pend   <= 1'b0;
      r_pend_j <= 2'd0;
      r_buf    <= '0;
      r_last_a <= '0;
      r_pc_o   <= '0;
      r_inst_o <= '0;
      r_valid  <= 1'b0;
    end else begin
      // The bus really carried this address, even if a redirect aborts now.
      if (w_issue) r_last_a <= w_mem_a;

      if (branch_flag_i) begin
        r_pc    <= branch_target_addr_i & ~32'h3;
        r_valid <= 1'b0;
        r_state <= ST_IDLE;
        r_k     <= '0;
        r_pend  <= 1'b0;
      end else begin
        unique case (r_state)
          ST_IDLE: begin
            if (w_slot_free) begin
              if (w_hit) begin
                r_pc_o   <= r_pc;
                r_inst_o <= w_line;
                r_valid  <= 1'b1;
                r_pc     <= r_pc + 32'd4;
              end else begin
                r_valid <= 1'b0;
                r_state <= ST_MISS;
                r_k     <= '0;
                r_pend  <= 1'b0;
              end
            end
          end

          ST_MISS: begin
            if (w_slot_free) r_valid <= 1'b0;
            r_pend <= w_issue;
            if (w_issue) begin
              r_pend_j <= r_k[1:0];
              r_k      <= r_k + BYTE_CNT_W'(1);
            end
            // Capture is independent of mem_busy_i: the read was already issued.
            if (r_pend) r_buf[{r_pend_j, 3'b000} +: 8] <= mem_din_i;
            if (w_last_byte) r_state <= ST_FILL;
          end

          ST_FILL: begin
            if (w_slot_free) begin
              r_pc_o   <= r_pc;
              r_inst_o <= r_buf;
              r_valid  <= 1'b1;
              r_pc     <= r_pc + 32'd4;
              r_state  <= ST_IDLE;
            end
          end

          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign mem_req_o    = w_issue;
  assign mem_a_o      = w_issue ? w_mem_a : r_last_a;
  assign pc_o         = r_pc_o;
  assign inst_o       = r_inst_o;
  assign inst_valid_o = r_valid;

endmodule

// File: tb/tb_if_fetch.sv
// ---------------------------------------------------------------------------
// tb_if_fetch
// Directed bench for if_fetch. A byte-wide memory answers each request one
// cycle later; expected words are hand-computed from its contents
// (0x0..0x3 = 13 05 A0 00, every other byte = addr[7:0] ^ 8'hA5).
// ---------------------------------------------------------------------------
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall_i = 1'b0;
  logic        branch_flag_i = 1'b0;
  logic [31:0] branch_target_addr_i = '0;
  logic        mem_busy_i = 1'b0;
  logic [7:0]  mem_din_i = '0;
  logic [31:0] mem_a_o;
  logic        mem_req_o;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        inst_valid_o;

  int n_checks = 0;
  int n_err    = 0;
  int n        = 0;

  always #5 clk = ~clk;

  if_fetch #(
    .ICACHE_IDX_W (7),
    .RESET_PC     (32'h0)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .stall_i              (stall_i),
    .branch_flag_i        (branch_flag_i),
    .branch_target_addr_i (branch_target_addr_i),
    .mem_busy_i           (mem_busy_i),
    .mem_din_i            (mem_din_i),
    .mem_a_o              (mem_a_o),
    .mem_req_o            (mem_req_o),
    .pc_o                 (pc_o),
    .inst_o               (inst_o),
    .inst_valid_o         (inst_valid_o)
  );

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    if (a < 32'd4) begin
      case (a[1:0])
        2'd0:    return 8'h13;
        2'd1:    return 8'h05;
        2'd2:    return 8'hA0;
        default: return 8'h00;
      endcase
    end
    return a[7:0] ^ 8'hA5;
  endfunction

  // Read data appears the cycle after the request; a filler byte otherwise.
  always @(posedge clk) mem_din_i <= mem_req_o ? mem_byte(mem_a_o) : 8'h3C;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input int budget, output int cycles);
    cycles = 0;
    while (!inst_valid_o && cycles < budget) begin
      tick();
      cycles++;
    end
  endtask

  task automatic redirect(input logic [31:0] target);
    branch_flag_i        = 1'b1;
    branch_target_addr_i = target;
    tick();
    branch_flag_i        = 1'b0;
  endtask

  initial begin
    logic [31:0] hit_inst [3];
    hit_inst[0] = 32'h00A00513;
    hit_inst[1] = 32'hA2A3A0A1;
    hit_inst[2] = 32'hAEAFACAD;

    // Reset state
    #3;
    check("rst_valid", inst_valid_o, 0);
    check("rst_pc",    pc_o, 0);
    check("rst_inst",  inst_o, 0);
    check("rst_req",   mem_req_o, 0);
    check("rst_addr",  mem_a_o, 0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Cold start: four consecutive byte reads, then valid two edges later
    for (int i = 0; i < 4; i++) begin
      tick();
      check("cold_req",  mem_req_o, 1);
      check("cold_addr", mem_a_o, i);
    end
    tick();
    check("cold_cap_req",   mem_req_o, 0);
    check("cold_cap_valid", inst_valid_o, 0);
    check("cold_cap_addr",  mem_a_o, 3);
    tick();
    check("cold_fill_valid", inst_valid_o, 0);
    tick();
    check("cold_valid", inst_valid_o, 1);
    check("cold_pc",    pc_o, 0);
    check("cold_inst",  inst_o, 32'h00A00513);

    // pc=4 misses next; fill 0x4 and 0x8
    tick();
    check("miss4_drop", inst_valid_o, 0);
    check("miss4_addr", mem_a_o, 32'h4);
    wait_valid(20, n);
    check("miss4_lat",  n, 6);
    check("miss4_pc",   pc_o, 32'h4);
    check("miss4_inst", inst_o, 32'hA2A3A0A1);
    tick();
    wait_valid(20, n);
    check("miss8_lat",  n, 6);
    check("miss8_pc",   pc_o, 32'h8);
    check("miss8_inst", inst_o, 32'hAEAFACAD);

    // Hit loop: one instruction per cycle, no memory traffic
    redirect(32'h0);
    check("loop_redir_valid", inst_valid_o, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hit_valid", inst_valid_o, 1);
      check("hit_pc",    pc_o, i * 4);
      check("hit_inst",  inst_o, hit_inst[i]);
      check("hit_req",   mem_req_o, 0);
    end

    // Stall hold while valid
    redirect(32'h0);
    tick();
    check("stall_pre_pc", pc_o, 0);
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_valid", inst_valid_o, 1);
      check("stall_pc",    pc_o, 0);
      check("stall_inst",  inst_o, 32'h00A00513);
    end
    stall_i = 1'b0;
    tick();
    check("unstall_valid", inst_valid_o, 1);
    check("unstall_pc",    pc_o, 32'h4);
    check("unstall_inst",  inst_o, 32'hA2A3A0A1);

    // Miss at 0x40 with mem_busy_i for two cycles during byte 2
    redirect(32'h40);
    check("busy_redir_valid", inst_valid_o, 0);
    tick();
    check("busy_req0",  mem_req_o, 1);
    check("busy_addr0", mem_a_o, 32'h40);
    tick();
    check("busy_addr1", mem_a_o, 32'h41);
    tick();
    mem_busy_i = 1'b1;
    #1;
    check("busy_hold_req_a",  mem_req_o, 0);
    check("busy_hold_addr_a", mem_a_o, 32'h41);
    tick();
    check("busy_hold_req_b",  mem_req_o, 0);
    check("busy_hold_addr_b", mem_a_o, 32'h41);
    mem_busy_i = 1'b0;
    #1;
    check("busy_req2",  mem_req_o, 1);
    check("busy_addr2", mem_a_o, 32'h42);
    tick();
    check("busy_addr3", mem_a_o, 32'h43);
    wait_valid(20, n);
    check("busy_tail_lat", n, 3);
    check("busy_pc",       pc_o, 32'h40);
    check("busy_inst",     inst_o, 32'hE6E7E4E5);

    // Redirect to 0x103 while byte 1 of the 0x100 miss is in flight
    redirect(32'h100);
    tick();
    check("abort_addr0", mem_a_o, 32'h100);
    tick();
    check("abort_addr1", mem_a_o, 32'h101);
    tick();
    check("abort_addr2", mem_a_o, 32'h102);
    branch_flag_i        = 1'b1;
    branch_target_addr_i = 32'h103;
    tick();
    branch_flag_i = 1'b0;
    check("abort_valid", inst_valid_o, 0);
    check("abort_req",   mem_req_o, 0);
    tick();
    check("refetch_req",  mem_req_o, 1);
    check("refetch_addr", mem_a_o, 32'h100);
    wait_valid(20, n);
    check("refetch_lat",  n, 6);
    check("refetch_pc",   pc_o, 32'h100);
    check("refetch_inst", inst_o, 32'hA6A7A4A5);

    // Asynchronous reset in the middle of the 0x104 miss
    tick();
    check("pre_rst_addr0", mem_a_o, 32'h104);
    tick();
    check("pre_rst_addr1", mem_a_o, 32'h105);
    #2;
    rst = 1'b0;
    #1;
    check("arst_valid", inst_valid_o, 0);
    check("arst_pc",    pc_o, 0);
    check("arst_inst",  inst_o, 0);
    check("arst_req",   mem_req_o, 0);
    check("arst_addr",  mem_a_o, 0);
    #3;
    rst = 1'b1;
    tick();
    check("post_rst_miss_req",  mem_req_o, 1);
    check("post_rst_miss_addr", mem_a_o, 0);
    wait_valid(20, n);
    check("post_rst_lat",  n, 6);
    check("post_rst_pc",   pc_o, 0);
    check("post_rst_inst", inst_o, 32'h00A00513);

    // Top of the address space: pc+4 wraps to 0, which hits
    redirect(32'hFFFF_FFFC);
    tick();
    check("wrap_addr0", mem_a_o, 32'hFFFF_FFFC);
    wait_valid(20, n);
    check("wrap_lat",  n, 6);
    check("wrap_pc",   pc_o, 32'hFFFF_FFFC);
    check("wrap_inst", inst_o, 32'h5A5B5859);
    tick();
    check("wrap_next_valid", inst_valid_o, 1);
    check("wrap_next_pc",    pc_o, 0);
    check("wrap_next_inst",  inst_o, 32'h00A00513);
    check("wrap_next_req",   mem_req_o, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
